regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: fixed-priority wb > link > md FIFO, with busy tracking
// for multicycle destinations and a starvation watchdog on the md result FIFO.
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        link_valid,
  input  logic [31:0] link_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ack,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        starve
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

  fifo_state_t state, state_next;

  logic [4:0]  head_rd, tail_rd;
  logic [31:0] head_data, tail_data;
  logic        push, pop;

  logic        sel_valid;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  logic [31:0] busy, busy_next;
  logic [3:0]  wait_count;

  assign md_ready = (state != FULL);
  assign push     = md_valid & md_ready;
  // Pop decision looks only at the registered state, so a push into EMPTY waits a cycle.
  assign pop      = ~wb_valid & ~link_valid & (state != EMPTY);

  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_rd   <= '0;
      head_data <= '0;
      tail_rd   <= '0;
      tail_data <= '0;
    end else if (pop && state == FULL) begin
      head_rd   <= tail_rd;
      head_data <= tail_data;
    end else if (push && (state == EMPTY || (state == ONE && pop))) begin
      head_rd   <= md_rd;
      head_data <= md_data;
    end else if (push && state == ONE) begin
      tail_rd   <= md_rd;
      tail_data <= md_data;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (wb_valid) begin
      sel_valid = 1'b1;
      sel_rd    = wb_rd;
      sel_data  = wb_data;
    end else if (link_valid) begin
      sel_valid = 1'b1;
      sel_rd    = 5'd31;
      sel_data  = link_pc - 32'd4;
    end else if (state != EMPTY) begin
      sel_valid = 1'b1;
      sel_rd    = head_rd;
      sel_data  = head_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= sel_valid & (sel_rd != '0);
      if (sel_valid) begin
        rf_rd    <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  assign issue_ack = issue_valid & ~busy[issue_rd];

  // Set after clear: a fresh issue to the register being retired keeps it busy.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_rd] = 1'b0;
    if (issue_ack && issue_rd != '0) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  always_ff @(posedge clock) begin
    if (reset)                        wait_count <= '0;
    else if (pop || state == EMPTY)   wait_count <= '0;
    else if (wait_count != 4'd8)      wait_count <= wait_count + 4'd1;
  end

  assign starve = (wait_count == 4'd8);
  assign stall  = busy[chk_rs] | busy[chk_rt] | starve;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based reference model.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        link_valid;
  logic [31:0] link_pc;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ack;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        starve;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .link_valid(link_valid), .link_pc(link_pc),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ack(issue_ack),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .stall(stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .starve(starve)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic idle();
    reset = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    link_valid = 1'b0; link_pc = '0; md_valid = 1'b0; md_rd = '0; md_data = '0;
    issue_valid = 1'b0; issue_rd = '0; chk_rs = '0; chk_rt = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    md_valid = 1'b1; md_rd = 5'd6; issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    idle();
    chk_rs = 5'd4; issue_valid = 1'b1; issue_rd = 5'd4;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rf_rd); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready got %b want 1", md_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (issue_ack !== 1'b1) begin errors++; $display("FAIL reset_issue_ack got %b want 1", issue_ack); end
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve got %b want 0", starve); end
  endtask

  task automatic test_priority();
    do_reset();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5A5A5;
    link_valid = 1'b1; link_pc = 32'h00400010;
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hA5A5A5A5)
      begin errors++; $display("FAIL prio_wb got we=%b rd=%0d d=%h want 1/5/a5a5a5a5", rf_we, rf_rd, rf_wdata); end
    tick();
    link_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd31 || rf_wdata !== 32'h0040000C)
      begin errors++; $display("FAIL prio_link got we=%b rd=%0d d=%h want 1/31/0040000c", rf_we, rf_rd, rf_wdata); end
    link_valid = 1'b1; link_pc = 32'h00000002;
    tick();
    link_valid = 1'b0;
    #1;
    checks++; if (rf_wdata !== 32'hFFFFFFFE) begin errors++; $display("FAIL link_wrap got %h want fffffffe", rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL prio_idle got %b want 0", rf_we); end
  endtask

  task automatic test_busy_md();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd8;
    #1;
    checks++; if (issue_ack !== 1'b1) begin errors++; $display("FAIL busy_ack got %b want 1", issue_ack); end
    tick();
    chk_rs = 5'd8;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall got %b want 1", stall); end
    checks++; if (issue_ack !== 1'b0) begin errors++; $display("FAIL busy_reissue got %b want 0", issue_ack); end
    issue_valid = 1'b0;
    md_valid = 1'b1; md_rd = 5'd8; md_data = 32'd7;
    tick();
    md_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall_hold got %b want 1", stall); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL md_no_passthru got %b want 0", rf_we); end
    tick();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd8 || rf_wdata !== 32'd7)
      begin errors++; $display("FAIL md_write got we=%b rd=%0d d=%h want 1/8/7", rf_we, rf_rd, rf_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL busy_clear got %b want 0", stall); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
    md_valid = 1'b1; md_rd = 5'd10; md_data = 32'h111;
    tick();
    md_rd = 5'd11; md_data = 32'h222;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got %b want 1", md_ready); end
    tick();
    md_rd = 5'd12; md_data = 32'h333;
    #1;
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_ready0 got %b want 0", md_ready); end
    tick();
    md_valid = 1'b0; wb_valid = 1'b0;
    tick();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'h111)
      begin errors++; $display("FAIL fifo_first got we=%b rd=%0d d=%h want 1/10/111", rf_we, rf_rd, rf_wdata); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL fifo_ready_after_pop got %b want 1", md_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd11 || rf_wdata !== 32'h222)
      begin errors++; $display("FAIL fifo_second got we=%b rd=%0d d=%h want 1/11/222", rf_we, rf_rd, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL fifo_dropped got %b want 0", rf_we); end
  endtask

  task automatic test_starve();
    do_reset();
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h9;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h55;
    tick();
    md_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_early got %b want 0", starve); end
    tick();
    #1;
    checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_set got %b want 1", starve); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL starve_stall got %b want 1", stall); end
    wb_valid = 1'b0;
    tick();
    #1;
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_drop got %b want 0", starve); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL starve_stall_drop got %b want 0", stall); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h55)
      begin errors++; $display("FAIL starve_pop got we=%b rd=%0d d=%h want 1/9/55", rf_we, rf_rd, rf_wdata); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    checks++; if (issue_ack !== 1'b1) begin errors++; $display("FAIL r0_ack got %b want 1", issue_ack); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %b want 0", rf_we); end
    checks++; if (issue_ack !== 1'b1) begin errors++; $display("FAIL r0_ack_again got %b want 1", issue_ack); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %b want 0", stall); end
  endtask

  task automatic test_reset_full();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd6;
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h1;
    tick();
    md_rd = 5'd4; md_data = 32'h2;
    tick();
    md_valid = 1'b0; chk_rs = 5'd3;
    #1;
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rfull_ready got %b want 0", md_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rfull_stall got %b want 1", stall); end
    reset = 1'b1;
    tick();
    idle();
    chk_rs = 5'd3;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rfull_ready_after got %b want 1", md_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rfull_stall_after got %b want 0", stall); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rfull_we_after got %b want 0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rfull_no_pop got %b want 0", rf_we); end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    bit   [31:0] m_busy;
    int          cnt;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        got, ack, do_pop;
    logic [4:0]  srd;
    logic [31:0] sdata;
    int          pre;
    do_reset();
    m_busy = '0; cnt = 0; exp_we = 1'b0; exp_rd = '0; exp_data = '0;
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(0, 79) == 0);
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      link_valid  = ($urandom_range(0, 5) == 0);
      link_pc     = $urandom;
      md_valid    = ($urandom_range(0, 1) == 0);
      md_rd       = 5'($urandom_range(0, 7));
      md_data     = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      chk_rs      = 5'($urandom_range(0, 7));
      chk_rt      = 5'($urandom_range(0, 7));
      #1;
      ack = issue_valid && !m_busy[issue_rd];
      checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL rnd_we n=%0d got %b want %b", n, rf_we, exp_we); end
      if (exp_we) begin
        checks++; if (rf_rd !== exp_rd || rf_wdata !== exp_data)
          begin errors++; $display("FAIL rnd_wr n=%0d got %0d/%h want %0d/%h", n, rf_rd, rf_wdata, exp_rd, exp_data); end
      end
      checks++; if (md_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready n=%0d got %b want %b", n, md_ready, q.size() < 2); end
      checks++; if (issue_ack !== ack) begin errors++; $display("FAIL rnd_ack n=%0d got %b want %b", n, issue_ack, ack); end
      checks++; if (starve !== (cnt == 8)) begin errors++; $display("FAIL rnd_starve n=%0d got %b want %b", n, starve, cnt == 8); end
      checks++; if (stall !== (m_busy[chk_rs] | m_busy[chk_rt] | (cnt == 8)))
        begin errors++; $display("FAIL rnd_stall n=%0d got %b", n, stall); end
      if (reset) begin
        q.delete(); m_busy = '0; cnt = 0; exp_we = 1'b0; exp_rd = '0; exp_data = '0;
      end else begin
        pre = q.size();
        do_pop = !wb_valid && !link_valid && pre > 0;
        got = 1'b1; srd = '0; sdata = '0;
        if (wb_valid)        begin srd = wb_rd; sdata = wb_data; end
        else if (link_valid) begin srd = 5'd31; sdata = link_pc - 32'd4; end
        else if (pre > 0)    begin srd = q[0].rd; sdata = q[0].data; end
        else                 got = 1'b0;
        exp_we = got && srd != 0;
        if (exp_we) begin exp_rd = srd; exp_data = sdata; end
        if (do_pop || pre == 0) cnt = 0;
        else if (cnt < 8)       cnt++;
        if (do_pop) begin m_busy[q[0].rd] = 1'b0; void'(q.pop_front()); end
        if (ack && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (md_valid && pre < 2) q.push_back('{md_rd, md_data});
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_priority();
    test_busy_md();
    test_fifo_full();
    test_starve();
    test_rd_zero();
    test_reset_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
